// File: rtl/mux_pkg.sv
// Shared constants and helpers for the stream multiplexer family.
package mux_pkg;

    localparam logic MODE_SEL = 1'b0;  // channel chosen by external sel
    localparam logic MODE_RR  = 1'b1;  // channel chosen by round-robin

    // Ceiling log2, used to size channel index fields.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority search: the first requester after ptr (wrapping) wins.
// Purely combinational; the pointer register belongs to the caller.
//   req         : per-channel request vector
//   ptr         : last granted channel; the search starts at ptr+1
//   grant_valid : some channel is requesting
//   grant_idx   : winning channel index (0 when grant_valid is low)
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int unsigned NUM_IN = 4,
    localparam int unsigned SEL_W  = clog2(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic              grant_valid,
    output logic [SEL_W-1:0]  grant_idx
);

    // Walk NUM_IN positions starting one past ptr; keep the first hit.
    always_comb begin : p_search
        int unsigned idx;
        logic [SEL_W-1:0] idx_s;
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        idx_s       = '0;
        for (int unsigned k = 1; k <= NUM_IN; k++) begin
            idx   = (32'(ptr) + k) % NUM_IN;
            idx_s = SEL_W'(idx);
            if (!grant_valid && req[idx_s]) begin
                grant_valid = 1'b1;
                grant_idx   = idx_s;
            end
        end
    end

endmodule

// File: rtl/stream_mux_nto1.sv
// N-to-1 valid/ready stream multiplexer with a registered output stage.
// Channel chosen by external sel (mode=0) or round-robin (mode=1).
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   mode, sel           : arbitration mode and external channel select
//   in_data/in_valid    : packed per-channel payloads and valids
//   in_ready            : per-channel ready (combinational, one-hot or zero)
//   out_data/out_src    : registered payload and its source channel
//   out_valid/out_ready : registered output handshake
module stream_mux_nto1
    import mux_pkg::*;
#(
    parameter  int unsigned WIDTH  = 32,
    parameter  int unsigned NUM_IN = 4,
    localparam int unsigned SEL_W  = clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_src,
    output logic                    out_valid,
    input  logic                    out_ready
);

    logic             load;
    logic             grant_valid;
    logic [SEL_W-1:0] grant_idx;
    logic             rr_valid;
    logic [SEL_W-1:0] rr_idx;
    logic [SEL_W-1:0] ptr;
    logic             sel_in_range;
    logic [WIDTH-1:0] ch_data [NUM_IN];

    // Unpack the flat input bus into per-channel words.
    for (genvar g = 0; g < NUM_IN; g++) begin : g_slice
        assign ch_data[g] = in_data[g*WIDTH +: WIDTH];
    end

    rr_arbiter #(
        .NUM_IN (NUM_IN)
    ) u_rr (
        .req         (in_valid),
        .ptr         (ptr),
        .grant_valid (rr_valid),
        .grant_idx   (rr_idx)
    );

    // Output register can take a beat when empty or draining this cycle.
    assign load         = !out_valid || out_ready;
    assign sel_in_range = (32'(sel) < NUM_IN);

    // Grant selection for the current mode.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        if (mode == MODE_RR) begin
            grant_valid = rr_valid;
            grant_idx   = rr_idx;
        end else if (sel_in_range) begin
            grant_valid = in_valid[sel];
            grant_idx   = sel;
        end
    end

    // Ready goes only to the granted channel; held low during reset so a
    // producer never sees a handshake that the register would discard.
    always_comb begin
        in_ready = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (!reset && load && grant_valid && (grant_idx == SEL_W'(i))) begin
                in_ready[i] = 1'b1;
            end
        end
    end

    // Output stage and round-robin pointer; data/src hold on empty loads.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            ptr       <= SEL_W'(NUM_IN - 1);
        end else if (load) begin
            out_valid <= grant_valid;
            if (grant_valid) begin
                out_data <= ch_data[grant_idx];
                out_src  <= grant_idx;
                if (mode == MODE_RR) begin
                    ptr <= grant_idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_nto1.sv
// Directed bench for stream_mux_nto1: a 4-channel instance driven from a
// vector table plus hand sequences, and a 3-channel instance for the
// out-of-range select case.
module tb_stream_mux_nto1;

    logic        clk = 1'b0;
    logic        reset;

    // 4-channel instance
    logic        mode;
    logic [1:0]  sel;
    logic [31:0] ch [4];
    logic [127:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [31:0] out_data;
    logic [1:0]  out_src;
    logic        out_valid;
    logic        out_ready;

    // 3-channel instance
    logic        m3_mode;
    logic [1:0]  m3_sel;
    logic [95:0] m3_in_data;
    logic [2:0]  m3_in_valid;
    logic [2:0]  m3_in_ready;
    logic [31:0] m3_out_data;
    logic [1:0]  m3_out_src;
    logic        m3_out_valid;
    logic        m3_out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign in_data    = {ch[3], ch[2], ch[1], ch[0]};
    assign m3_in_data = {32'hC3C3_0002, 32'hC3C3_0001, 32'hC3C3_0000};

    stream_mux_nto1 #(.WIDTH(32), .NUM_IN(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    stream_mux_nto1 #(.WIDTH(32), .NUM_IN(3)) dut3 (
        .clk       (clk),
        .reset     (reset),
        .mode      (m3_mode),
        .sel       (m3_sel),
        .in_data   (m3_in_data),
        .in_valid  (m3_in_valid),
        .in_ready  (m3_in_ready),
        .out_data  (m3_out_data),
        .out_src   (m3_out_src),
        .out_valid (m3_out_valid),
        .out_ready (m3_out_ready)
    );

    typedef struct {
        logic       mode;
        logic [1:0] sel;
        logic [3:0] valid;
        logic       ordy;
        logic [3:0] exp_rdy;   // in_ready before the edge
        logic       exp_ov;    // out_valid after the edge
        logic [1:0] exp_src;   // out_src after the edge (data is A5A5_000<src>)
    } vec_t;

    localparam int NV = 17;
    vec_t vt [NV];

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    initial begin
        // mode, sel, valid, ordy, exp_rdy, exp_ov, exp_src
        vt[0]  = '{1'b0, 2'd2, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2};
        vt[1]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
        vt[2]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
        vt[3]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};
        vt[4]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3};
        vt[5]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
        vt[6]  = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1};
        vt[7]  = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3};
        vt[8]  = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1};
        vt[9]  = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3};
        vt[10] = '{1'b1, 2'd0, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1};
        vt[11] = '{1'b1, 2'd0, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1};
        vt[12] = '{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1};
        vt[13] = '{1'b0, 2'd1, 4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1};
        vt[14] = '{1'b0, 2'd3, 4'b1000, 1'b0, 4'b0000, 1'b1, 2'd1};
        vt[15] = '{1'b0, 2'd3, 4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3};
        vt[16] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};

        for (int i = 0; i < 4; i++) ch[i] = 32'hA5A5_0000 | 32'(i);
        reset = 1'b1; mode = 1'b0; sel = '0; in_valid = '0; out_ready = 1'b1;
        m3_mode = 1'b0; m3_sel = '0; m3_in_valid = '0; m3_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 0, 32'(out_valid), 32'd0);
        chk("rst_out_data",  0, out_data, 32'd0);
        chk("rst_out_src",   0, 32'(out_src), 32'd0);
        chk("rst_out_valid3", 0, 32'(m3_out_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Table-driven vectors on the 4-channel instance.
        for (int i = 0; i < NV; i++) begin
            mode = vt[i].mode; sel = vt[i].sel;
            in_valid = vt[i].valid; out_ready = vt[i].ordy;
            #1;
            chk("tbl_in_ready", i, 32'(in_ready), 32'(vt[i].exp_rdy));
            @(posedge clk); #1;
            chk("tbl_out_valid", i, 32'(out_valid), 32'(vt[i].exp_ov));
            chk("tbl_out_src",   i, 32'(out_src),   32'(vt[i].exp_src));
            chk("tbl_out_data",  i, out_data, 32'hA5A5_0000 | 32'(vt[i].exp_src));
            @(negedge clk);
        end

        // Backpressure: hold a beat for 3 cycles, then drain and refill together.
        ch[0] = 32'h1111_0000;
        mode = 1'b0; sel = 2'd0; in_valid = 4'b0001; out_ready = 1'b1;
        #1 chk("bp_load_rdy", 0, 32'(in_ready), 32'b0001);
        @(posedge clk); #1;
        chk("bp_load_data", 0, out_data, 32'h1111_0000);
        @(negedge clk);
        ch[1] = 32'h2222_0001;
        sel = 2'd1; in_valid = 4'b0011; out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1 chk("bp_stall_rdy", c, 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            chk("bp_stall_valid", c, 32'(out_valid), 32'd1);
            chk("bp_stall_data",  c, out_data, 32'h1111_0000);
            chk("bp_stall_src",   c, 32'(out_src), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1 chk("bp_refill_rdy", 0, 32'(in_ready), 32'b0010);
        @(posedge clk); #1;
        chk("bp_refill_valid", 0, 32'(out_valid), 32'd1);
        chk("bp_refill_data",  0, out_data, 32'h2222_0001);
        chk("bp_refill_src",   0, 32'(out_src), 32'd1);
        @(negedge clk);
        ch[0] = 32'hA5A5_0000; ch[1] = 32'hA5A5_0001;

        // Reset mid-stream after a round-robin grant to channel 2 (ptr is 2).
        mode = 1'b1; in_valid = 4'b0100; out_ready = 1'b1;
        #1 chk("mid_rst_pre_rdy", 0, 32'(in_ready), 32'b0100);
        @(posedge clk); #1;
        chk("mid_rst_pre_src", 0, 32'(out_src), 32'd2);
        @(negedge clk);
        reset = 1'b1; in_valid = 4'b1111; out_ready = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_valid", 0, 32'(out_valid), 32'd0);
        chk("mid_rst_data",  0, out_data, 32'd0);
        chk("mid_rst_src",   0, 32'(out_src), 32'd0);
        chk("mid_rst_rdy",   0, 32'(in_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0; out_ready = 1'b1;
        #1 chk("post_rst_rdy", 0, 32'(in_ready), 32'b0001);
        @(posedge clk); #1;
        chk("post_rst_src",  0, 32'(out_src), 32'd0);
        chk("post_rst_data", 0, out_data, 32'hA5A5_0000);
        @(negedge clk);

        // 3-channel instance: out-of-range select never grants.
        m3_sel = 2'd2; m3_in_valid = 3'b111;
        #1 chk("n3_sel2_rdy", 0, 32'(m3_in_ready), 32'b100);
        @(posedge clk); #1;
        chk("n3_sel2_valid", 0, 32'(m3_out_valid), 32'd1);
        chk("n3_sel2_data",  0, m3_out_data, 32'hC3C3_0002);
        @(negedge clk);
        m3_sel = 2'd3;
        for (int c = 0; c < 2; c++) begin
            #1 chk("n3_sel3_rdy", c, 32'(m3_in_ready), 32'd0);
            @(posedge clk); #1;
            chk("n3_sel3_valid", c, 32'(m3_out_valid), 32'd0);
            chk("n3_sel3_src",   c, 32'(m3_out_src), 32'd2);
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
